// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Reorders FFT output frames from bit-reversed order into natural order.
// Two ping/pong banks of N samples: the write side fills one bank at
// bit-reversed addresses while the read side drains the other bank in
// linear order. Each bank has a full flag; a bank is handed from writer
// to reader when its last sample is written, and back when its last
// sample is read. Samples pass through bit-exact.

module fft_bitrev_reorder #(
  parameter int DW    = 50,
  parameter int LOG2N = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] signal_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] signal_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  // Reverse the bit order of a frame index (LOG2N bits wide).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int b = 0; b < LOG2N; b++) begin
      rev[b] = idx[LOG2N-1-b];
    end
    return rev;
  endfunction

  // Sample storage and control state.
  logic [DW-1:0]    r_bank0 [N];
  logic [DW-1:0]    r_bank1 [N];
  logic [1:0]       r_full;
  logic             r_wb;
  logic             r_rb;
  logic [LOG2N-1:0] r_wcnt;
  logic [LOG2N-1:0] r_rcnt;

  // Handshake and frame-boundary decodes.
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_wr_wrap;
  logic             w_rd_wrap;
  logic [LOG2N-1:0] w_waddr;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic [1:0]       w_full_nxt;

  // Port outputs come straight from registered state; no path from valid_i or ready_i.
  always_comb begin
    ready_o = ~r_full[r_wb];
    valid_o = r_full[r_rb];
    if (r_rb) begin
      signal_o = r_bank1[r_rcnt];
    end else begin
      signal_o = r_bank0[r_rcnt];
    end
  end

  // Handshake detection, write address and next full-flag value.
  // The writer only wraps into a bank whose flag is clear and the reader only
  // wraps out of a bank whose flag is set, so set and clear never hit the
  // same bank and both may land on one edge.
  always_comb begin
    w_wr_acc  = valid_i & ready_o;
    w_rd_acc  = valid_o & ready_i;
    w_wr_wrap = w_wr_acc & (r_wcnt == CNT_LAST);
    w_rd_wrap = w_rd_acc & (r_rcnt == CNT_LAST);
    w_waddr   = bitrev(r_wcnt);
    if (w_wr_wrap) begin
      w_full_set = 2'b01 << r_wb;
    end else begin
      w_full_set = 2'b00;
    end
    if (w_rd_wrap) begin
      w_full_clr = 2'b01 << r_rb;
    end else begin
      w_full_clr = 2'b00;
    end
    w_full_nxt = (r_full | w_full_set) & ~w_full_clr;
  end

  // Write side: bank pointer and sample counter within the frame being filled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb   <= 1'b0;
      r_wcnt <= '0;
    end else if (w_wr_wrap) begin
      r_wb   <= ~r_wb;
      r_wcnt <= '0;
    end else if (w_wr_acc) begin
      r_wcnt <= r_wcnt + CNT_ONE;
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  // Read side: bank pointer and linear read counter; both hold under backpressure.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rb   <= 1'b0;
      r_rcnt <= '0;
    end else if (w_rd_wrap) begin
      r_rb   <= ~r_rb;
      r_rcnt <= '0;
    end else if (w_rd_acc) begin
      r_rcnt <= r_rcnt + CNT_ONE;
    end else begin
      r_rcnt <= r_rcnt;
    end
  end

  // Per-bank full flags handing each bank between writer and reader.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // Bank 0 storage, written at the bit-reversed address of the current sample.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) begin
        r_bank0[i] <= '0;
      end
    end else if (w_wr_acc && !r_wb) begin
      r_bank0[w_waddr] <= signal_i;
    end else begin
      r_bank0[w_waddr] <= r_bank0[w_waddr];
    end
  end

  // Bank 1 storage, written at the bit-reversed address of the current sample.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) begin
        r_bank1[i] <= '0;
      end
    end else if (w_wr_acc && r_wb) begin
      r_bank1[w_waddr] <= signal_i;
    end else begin
      r_bank1[w_waddr] <= r_bank1[w_waddr];
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder: a directed vector table, directed
// multi-cycle sequences and a long random run, all checked every cycle
// against a frame-level reference model (queues plus index reversal).

module tb_fft_bitrev_reorder;

  localparam int DW    = 50;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  logic          clk;
  logic          rst_i;
  logic [DW-1:0] signal_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] signal_o;
  logic          valid_o;
  logic          ready_i;

  int n_checks;
  int n_errors;
  int n_out;
  int cyc;

  // Reference model: samples of the frame being received, and samples due out in order.
  logic [DW-1:0] cur_frame [$];
  logic [DW-1:0] exp_out   [$];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_sig;
  } vec_t;

  vec_t tab [17];

  fft_bitrev_reorder #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .signal_i (signal_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .signal_o (signal_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index reversal by repeated halving.
  function automatic int rev_idx(input int k);
    int x;
    int r;
    x = k;
    r = 0;
    repeat (LOG2N) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // A bank stays occupied until its last sample has left.
  function automatic int banks_full();
    return (exp_out.size() + N - 1) / N;
  endfunction

  function automatic logic model_ready();
    return banks_full() < 2;
  endfunction

  function automatic logic model_valid();
    return banks_full() > 0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model (and,
  // optionally, against a table entry), drive inputs, then advance the model
  // through the rising edge.
  task automatic step_t(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic use_tab, input logic t_rdy, input logic t_vld,
                        input logic [DW-1:0] t_sig);
    logic in_acc;
    logic out_acc;
    @(negedge clk);
    chk("ready_o", {63'd0, ready_o}, {63'd0, model_ready()});
    chk("valid_o", {63'd0, valid_o}, {63'd0, model_valid()});
    if (model_valid()) begin
      chk("signal_o", 64'(signal_o), 64'(exp_out[0]));
    end
    if (use_tab) begin
      chk("tab_ready", {63'd0, ready_o}, {63'd0, t_rdy});
      chk("tab_valid", {63'd0, valid_o}, {63'd0, t_vld});
      if (t_vld) begin
        chk("tab_signal", 64'(signal_o), 64'(t_sig));
      end
    end
    valid_i  = v;
    signal_i = d;
    ready_i  = r;
    in_acc   = v && model_ready();
    out_acc  = model_valid() && r;
    @(posedge clk);
    cyc++;
    if (out_acc) begin
      void'(exp_out.pop_front());
      n_out++;
    end
    if (in_acc) begin
      cur_frame.push_back(d);
      if (cur_frame.size() == N) begin
        for (int n = 0; n < N; n++) begin
          exp_out.push_back(cur_frame[rev_idx(n)]);
        end
        cur_frame.delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    step_t(v, d, r, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Assert reset between edges; outputs must respond without waiting for a clock.
  task automatic reset_between_edges(input string nm);
    #2;
    rst_i = 1'b0;
    #1;
    chk({nm, "_ready"},  {63'd0, ready_o}, 64'd1);
    chk({nm, "_valid"},  {63'd0, valid_o}, 64'd0);
    chk({nm, "_signal"}, 64'(signal_o),    64'd0);
    exp_out.delete();
    cur_frame.delete();
    valid_i = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  initial begin
    int seq [N];
    int budget;
    int start_out;

    n_checks = 0;
    n_errors = 0;
    n_out    = 0;
    cyc      = 0;
    rst_i    = 1'b0;
    valid_i  = 1'b0;
    signal_i = '0;
    ready_i  = 1'b0;

    // Single-frame vector table: bit-reversed inputs 0,4,2,6,1,5,3,7 then natural outputs.
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int c = 0; c < 17; c++) begin
      tab[c].v     = (c < N);
      tab[c].d     = (c < N) ? DW'(seq[c]) : '0;
      tab[c].r     = 1'b1;
      tab[c].e_rdy = 1'b1;
      tab[c].e_vld = (c >= N) && (c < 2 * N);
      tab[c].e_sig = (c >= N) ? DW'(c - N) : '0;
    end

    // Reset state.
    #1;
    chk("rst_ready",  {63'd0, ready_o}, 64'd1);
    chk("rst_valid",  {63'd0, valid_o}, 64'd0);
    chk("rst_signal", 64'(signal_o),    64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;

    // Single frame from the table.
    for (int c = 0; c < 17; c++) begin
      step_t(tab[c].v, tab[c].d, tab[c].r, 1'b1, tab[c].e_rdy, tab[c].e_vld, tab[c].e_sig);
    end

    // Four back-to-back frames; frame k+1's last input meets frame k's last output.
    for (int i = 0; i < 4 * N + N + 2; i++) begin
      step(i < 4 * N, rand_data(), 1'b1);
    end

    // Backpressure: two frames fill both banks, input stalls, then drains.
    for (int i = 0; i < 2 * N + 4; i++) begin
      step(1'b1, rand_data(), 1'b0);
    end
    chk("bp_stalled", {63'd0, ready_o}, 64'd0);
    for (int i = 0; i < 2 * N + 3; i++) begin
      step(1'b0, rand_data(), 1'b1);
    end

    // Reset mid-frame with one complete frame buffered and five samples of the next.
    for (int i = 0; i < N + 5; i++) begin
      step(1'b1, rand_data(), 1'b0);
    end
    chk("pre_reset_valid", {63'd0, valid_o}, 64'd1);
    reset_between_edges("async_rst");
    for (int i = 0; i < 3 * N; i++) begin
      step(i < N, rand_data(), 1'b1);
    end

    // Random valid/ready with random data for 1000 frames.
    start_out = n_out;
    budget    = cyc + 60000;
    while ((n_out - start_out) < 1000 * N && cyc < budget) begin
      step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) != 0);
    end
    chk("random_frames_done", 64'(n_out - start_out), 64'(1000 * N));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
